// File: rtl/fifo_serial_tx_if.sv
// FIFO-side handshake bundle for fifo_serial_tx.
// The master modport belongs to the FIFO and the slave modport to the transmitter.
interface fifo_serial_tx_if #(
  parameter int unsigned data_width = 8
);
  logic                  fifo_empty;
  logic                  fifo_wn;
  logic [data_width-1:0] fifo_data;
  logic                  fifo_rn;

  modport master (
    output fifo_empty,
    output fifo_wn,
    output fifo_data,
    input  fifo_rn
  );

  modport slave (
    input  fifo_empty,
    input  fifo_wn,
    input  fifo_data,
    output fifo_rn
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Pops one word from a synchronous FIFO and sends it as a UART-style frame:
// one start bit, LSB-first data, one stop bit. All outputs are decoded from registered state.
module fifo_serial_tx #(
  parameter int unsigned data_width   = 8,
  parameter int unsigned clks_per_bit = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  fifo_serial_tx_if.slave fifo,
  output logic            tx,
  output logic            busy,
  output logic            done
);
  localparam int unsigned CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int unsigned BW = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(clks_per_bit - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(data_width - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic                  rn;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (enable && !fifo.fifo_empty) state_d = POP;
      // A concurrent FIFO write wins over our read, so the pop is retried from IDLE.
      POP: state_d = (fifo.fifo_empty || fifo.fifo_wn) ? IDLE : LOAD;
      LOAD: begin
        shift_d = fifo.fifo_data;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    rn   = 1'b0;
    done = 1'b0;
    busy = (state_q != IDLE);
    case (state_q)
      POP:   rn   = 1'b1;
      START: tx   = 1'b0;
      DATA:  tx   = shift_q[0];
      STOP:  done = (cnt_q == CNT_LAST);
      default: ;
    endcase
  end

  assign fifo.fifo_rn = rn;
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx (data_width=8, clks_per_bit=4): frame table plus
// hand sequences for write collision, empty FIFO, mid-frame reset and enable drop.
module tb_fifo_serial_tx;
  logic clock = 1'b0;
  logic reset, enable;
  logic tx, busy, done;
  int   total = 0;
  int   bad   = 0;

  fifo_serial_tx_if #(.data_width(8)) fif();

  fifo_serial_tx #(.data_width(8), .clks_per_bit(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .fifo   (fif.slave),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  // frame bit 0 = start level, bits 1..8 = data LSB first, bit 9 = stop level
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    bit         empty_after;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_idle(input string name, input int idx);
    check(name, idx, {28'd0, tx, busy, done, fif.fifo_rn}, 32'b1000);
  endtask

  // Offers a word, checks POP and LOAD, and returns in the first START cycle.
  task automatic pop_load(input logic [7:0] d, input bit empty_after);
    fif.fifo_data  = d;
    fif.fifo_empty = 1'b0;
    enable         = 1'b1;
    tick();
    check("pop_rn", d, fif.fifo_rn, 1);
    check("pop_tx", d, tx, 1);
    check("pop_busy", d, busy, 1);
    tick();
    check("load_rn", d, fif.fifo_rn, 0);
    check("load_tx", d, tx, 1);
    check("load_busy", d, busy, 1);
    if (empty_after) fif.fifo_empty = 1'b1;
    tick();
    fif.fifo_data = ~d;
  endtask

  task automatic frame(input logic [9:0] exp, input int drop_at);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick();
      if (c == drop_at) enable = 1'b0;
      check("frame_tx", c, tx, exp[c/4]);
      check("frame_done", c, done, c == 39);
      check("frame_rn", c, fif.fifo_rn, 0);
      check("frame_busy", c, busy, 1);
    end
  endtask

  task automatic idle_after();
    tick();
    check_idle("idle_after", 0);
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    fif.fifo_empty = 1'b1;
    fif.fifo_wn    = 1'b0;
    fif.fifo_data  = 8'h00;
    tick();
    tick();
    check_idle("reset_state", 0);
    reset = 1'b0;
    tick();
    check_idle("post_reset", 0);

    vecs[0] = '{data: 8'hA5, frame: 10'h34A, empty_after: 1'b1};
    vecs[1] = '{data: 8'h00, frame: 10'h200, empty_after: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE, empty_after: 1'b1};
    for (int i = 0; i < 3; i++) begin
      pop_load(vecs[i].data, vecs[i].empty_after);
      frame(vecs[i].frame, -1);
      idle_after();
    end

    // write strobe during POP blocks the read; retry then succeeds
    fif.fifo_data  = 8'h5A;
    fif.fifo_empty = 1'b0;
    enable         = 1'b1;
    tick();
    check("wn_pop_rn", 0, fif.fifo_rn, 1);
    fif.fifo_wn = 1'b1;
    tick();
    check_idle("wn_abort", 0);
    fif.fifo_wn = 1'b0;
    pop_load(8'h5A, 1'b1);
    frame(10'h2B4, -1);
    idle_after();

    // empty FIFO with enable high: nothing happens
    enable         = 1'b1;
    fif.fifo_empty = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_idle("empty_hold", i);
    end

    // reset in cycle 15 of a 0x3C frame
    pop_load(8'h3C, 1'b1);
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      check("rst_frame_tx", c, tx, (c < 4) ? 0 : (c < 8) ? 0 : (c < 12) ? 0 : 1);
      if (c == 14) reset = 1'b1;
    end
    tick();
    check_idle("rst_mid", 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("rst_quiet", i);
    end
    pop_load(8'h81, 1'b1);
    frame(10'h302, -1);
    idle_after();

    // enable dropped in cycle 10: frame completes, no further reads
    pop_load(8'hC3, 1'b1);
    frame(10'h386, 9);
    idle_after();
    fif.fifo_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("en_low_hold", i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
